// File: rtl/ser_tx_scheduler_if.sv
// Requester byte streams plus the serializer-side symbol bus and status of
// the lane scheduler. The scheduler itself uses the slave modport.
interface ser_tx_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          i_ser_ready;
  logic                          o_sym_valid;
  logic [DATA_WIDTH-1:0]         o_sym_data;
  logic                          o_sym_k;
  logic [2:0]                    o_grant;
  logic                          o_busy;
  logic [7:0]                    o_underrun_cnt;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_ser_ready,
    input  o_req_ready, o_sym_valid, o_sym_data, o_sym_k,
           o_grant, o_busy, o_underrun_cnt
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_ser_ready,
    output o_req_ready, o_sym_valid, o_sym_data, o_sym_k,
           o_grant, o_busy, o_underrun_cnt
  );
endinterface

// File: rtl/ser_tx_scheduler.sv
// Symbol scheduler feeding one 8b/10b serializer lane. Requesters share the
// lane with packet-locked round-robin arbitration; idle slots, underrun slots
// and periodic alignment slots are filled with the K28.5 comma.
module ser_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int COMMA_PERIOD = 16
) (
  input logic               clk,
  input logic               i_rst_n,
  ser_tx_scheduler_if.slave bus
);

  localparam int CW = $clog2(COMMA_PERIOD + 1);
  localparam logic [DATA_WIDTH-1:0] K28_5 = DATA_WIDTH'(8'hBC);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state, state_nxt;
  logic [2:0]            ptr, ptr_nxt;
  logic [2:0]            grant, grant_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [7:0]            urun, urun_nxt;

  logic                  gnt_valid, gnt_last;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  arb_found;
  logic [2:0]            arb_idx;
  logic                  force_k;
  logic [NUM_REQ-1:0]    req_ready;

  logic                  vld_p0, sym_k_p0;
  logic [DATA_WIDTH-1:0] sym_data_p0;
  logic                  vld_p1, sym_k_p1;
  logic [DATA_WIDTH-1:0] sym_data_p1;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [2:0] wrap_inc(input logic [2:0] g);
    return (g == 3'(NUM_REQ - 1)) ? 3'd0 : g + 3'd1;
  endfunction

  assign force_k = (cnt == CW'(COMMA_PERIOD));

  // Select the grant holder's valid/last/data lanes.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    gnt_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == 3'(i)) begin
        gnt_valid = bus.i_req_valid[i];
        gnt_last  = bus.i_req_last[i];
        gnt_data  = bus.i_req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!arb_found && bus.i_req_valid[i] && ((int'(ptr) + k) % NUM_REQ == i)) begin
          arb_found = 1'b1;
          arb_idx   = 3'(i);
        end
      end
    end
  end

  // Ready goes only to the grant holder on a data slot (not a forced comma).
  always_comb begin
    req_ready = '0;
    if (bus.i_ser_ready && (state == XFER) && !force_k) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant == 3'(i)) req_ready[i] = bus.i_req_valid[i];
      end
    end
  end

  assign bus.o_req_ready = req_ready;

  // Next-state and symbol decision for this slot.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    grant_nxt   = grant;
    cnt_nxt     = cnt;
    urun_nxt    = urun;
    vld_p0      = 1'b0;
    sym_k_p0    = 1'b0;
    sym_data_p0 = '0;
    case (state)
      IDLE: begin
        if (bus.i_ser_ready) begin
          vld_p0      = 1'b1;
          sym_k_p0    = 1'b1;
          sym_data_p0 = K28_5;
          cnt_nxt     = '0;
        end
        if (arb_found) begin
          grant_nxt = arb_idx;
          state_nxt = XFER;
        end
      end
      XFER: begin
        if (bus.i_ser_ready) begin
          vld_p0 = 1'b1;
          if (force_k) begin
            sym_k_p0    = 1'b1;
            sym_data_p0 = K28_5;
            cnt_nxt     = '0;
          end else if (gnt_valid) begin
            sym_data_p0 = gnt_data;
            cnt_nxt     = cnt + CW'(1);
            if (gnt_last) begin
              state_nxt = IDLE;
              ptr_nxt   = wrap_inc(grant);
            end
          end else begin
            sym_k_p0    = 1'b1;
            sym_data_p0 = K28_5;
            cnt_nxt     = '0;
            urun_nxt    = sat_inc8(urun);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: control state and registered symbol output ----
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      cnt         <= '0;
      urun        <= '0;
      vld_p1      <= 1'b0;
      sym_k_p1    <= 1'b0;
      sym_data_p1 <= '0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      grant       <= grant_nxt;
      cnt         <= cnt_nxt;
      urun        <= urun_nxt;
      vld_p1      <= vld_p0;
      sym_k_p1    <= sym_k_p0;
      sym_data_p1 <= sym_data_p0;
    end
  end

  assign bus.o_sym_valid    = vld_p1;
  assign bus.o_sym_data     = sym_data_p1;
  assign bus.o_sym_k        = sym_k_p1;
  assign bus.o_grant        = grant;
  assign bus.o_busy         = (state == XFER);
  assign bus.o_underrun_cnt = urun;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Directed bench for ser_tx_scheduler (NUM_REQ=4, COMMA_PERIOD=4). The driver
// pushes each slot's hand-computed symbol into a queue; a monitor pops and
// compares whenever the scheduler presents a symbol.
module tb_ser_tx_scheduler;

  logic clk;
  logic rst_n;

  ser_tx_scheduler_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  ser_tx_scheduler #(
    .NUM_REQ(4),
    .DATA_WIDTH(8),
    .COMMA_PERIOD(4)
  ) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [8:0] exp_q[$];
  logic [8:0] sb_exp;
  logic       prev_slot = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // A slot seen while out of reset must yield a symbol one cycle later.
  always @(posedge clk) prev_slot <= bus.i_ser_ready && rst_n;

  // Monitor: symbol timing and content against the scoreboard queue.
  always @(negedge clk) begin
    if (bus.o_sym_valid === 1'b1 || prev_slot) begin
      n_total++;
      if (bus.o_sym_valid === prev_slot) n_pass++;
      else $display("FAIL sym_timing: sym_valid %b, expected %b", bus.o_sym_valid, prev_slot);
    end
    if (bus.o_sym_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_extra: got k=%b data=%h, expected no symbol", bus.o_sym_k, bus.o_sym_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if ({bus.o_sym_k, bus.o_sym_data} === sb_exp) n_pass++;
        else $display("FAIL sb_symbol: got k=%b data=%h, expected k=%b data=%h",
                      bus.o_sym_k, bus.o_sym_data, sb_exp[8], sb_exp[7:0]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.i_ser_ready = 1'b0;
    repeat (n) step();
  endtask

  // Slot on which requester r must hand over byte b.
  task automatic slot_d(input int r, input logic [7:0] b, input logic last);
    bus.i_req_data[8*r +: 8] = b;
    bus.i_req_last  = last ? 4'(1 << r) : 4'b0000;
    bus.i_ser_ready = 1'b1;
    #1;
    check("ready_data", 32'(bus.o_req_ready), 32'(1 << r));
    exp_q.push_back({1'b0, b});
    step();
  endtask

  // Slot that must carry K28.5 with no ready.
  task automatic slot_k();
    bus.i_ser_ready = 1'b1;
    #1;
    check("ready_comma", 32'(bus.o_req_ready), 32'h0);
    exp_q.push_back({1'b1, 8'hBC});
    step();
  endtask

  // IDLE cycle raising requests; slot selects a simultaneous idle comma.
  task automatic arb(input logic [3:0] v, input logic slot, input int exp_g);
    bus.i_req_valid = v;
    bus.i_ser_ready = slot;
    if (slot) exp_q.push_back({1'b1, 8'hBC});
    #1;
    check("ready_arb", 32'(bus.o_req_ready), 32'h0);
    step();
    check("busy_grant", 32'(bus.o_busy), 32'h1);
    check("grant", 32'(bus.o_grant), 32'(exp_g));
  endtask

  initial begin
    string pat;
    int    j;
    int    rot_g[5];
    pat   = "DDDDKDDDDKDD";
    rot_g = '{0, 1, 2, 3, 0};

    // Reset with live inputs: nothing may arbitrate or emit.
    rst_n           = 1'b0;
    bus.i_req_valid = 4'b0001;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_ser_ready = 1'b1;
    repeat (3) step();
    check("rst_sym_valid", 32'(bus.o_sym_valid), 32'h0);
    check("rst_busy",      32'(bus.o_busy), 32'h0);
    check("rst_grant",     32'(bus.o_grant), 32'h0);
    check("rst_underrun",  32'(bus.o_underrun_cnt), 32'h0);
    bus.i_req_valid = '0;
    bus.i_ser_ready = 1'b0;
    rst_n           = 1'b1;
    step();

    // Idle link: slot every 10 cycles gives K28.5 only.
    for (int s = 0; s < 3; s++) begin
      idle(9);
      slot_k();
    end
    idle(2);

    // Requester 2, packet 11 22 33 44; slots begin the cycle after grant.
    arb(4'b0100, 1'b0, 2);
    slot_d(2, 8'h11, 1'b0);
    slot_d(2, 8'h22, 1'b0);
    slot_d(2, 8'h33, 1'b0);
    slot_d(2, 8'h44, 1'b1);
    check("pkt_end_busy", 32'(bus.o_busy), 32'h0);
    bus.i_req_valid = '0;
    idle(2);

    // Pointer is now 3: requesters 0 and 3 valid, 3 wins. Forced commas
    // every 4 data symbols with the slot held high.
    arb(4'b1001, 1'b1, 3);
    j = 0;
    for (int p = 0; p < pat.len(); p++) begin
      if (pat[p] == "D") begin
        slot_d(3, 8'(j + 1), j == 9);
        j++;
      end else begin
        bus.i_req_data[31:24] = 8'(j + 1);
        slot_k();
        check("comma_grant", 32'(bus.o_grant), 32'h3);
      end
    end
    check("comma_end_busy", 32'(bus.o_busy), 32'h0);
    bus.i_req_valid = '0;
    idle(2);

    // All requesters valid, single-byte packets, slot held high.
    for (int p = 0; p < 5; p++) begin
      arb(4'b1111, 1'b1, rot_g[p]);
      slot_d(rot_g[p], 8'hA0 + 8'(rot_g[p]), 1'b1);
      check("rot_busy", 32'(bus.o_busy), 32'h0);
    end
    bus.i_req_valid = '0;
    idle(2);

    // Pointer 1: requester 1 granted, drops valid for 3 slots mid-packet.
    arb(4'b0011, 1'b1, 1);
    slot_d(1, 8'h51, 1'b0);
    slot_d(1, 8'h52, 1'b0);
    bus.i_req_valid = 4'b0001;
    repeat (3) begin
      slot_k();
      check("urun_grant", 32'(bus.o_grant), 32'h1);
    end
    check("urun_cnt", 32'(bus.o_underrun_cnt), 32'h3);
    bus.i_req_valid = 4'b0011;
    slot_d(1, 8'h53, 1'b0);
    slot_d(1, 8'h54, 1'b1);
    check("urun_end_busy", 32'(bus.o_busy), 32'h0);
    check("urun_cnt_end", 32'(bus.o_underrun_cnt), 32'h3);
    bus.i_req_valid = '0;
    idle(2);

    // Pointer 2: requester 2 sends 2 of 5 bytes, then reset.
    arb(4'b0101, 1'b0, 2);
    slot_d(2, 8'h61, 1'b0);
    slot_d(2, 8'h62, 1'b0);
    bus.i_ser_ready = 1'b0;
    rst_n           = 1'b0;
    step();
    check("mid_rst_busy",     32'(bus.o_busy), 32'h0);
    check("mid_rst_sym",      32'(bus.o_sym_valid), 32'h0);
    check("mid_rst_underrun", 32'(bus.o_underrun_cnt), 32'h0);
    rst_n = 1'b1;
    // From pointer 0 requester 0 wins (a stale pointer of 2 would pick 3).
    arb(4'b1011, 1'b0, 0);
    slot_d(0, 8'h71, 1'b1);
    bus.i_req_valid = '0;
    idle(4);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
